// File: rtl/axis_read_ctrl_pkg.sv
// Shared definitions for the AXI read-address controller: FSM encoding,
// default beat size and the 4 KB burst boundary.
package axis_read_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DATA_CFG = 2'd1,
        CALC     = 2'd2,
        ADDR     = 2'd3
    } state_t;

    // Bytes carried by one AXI data beat at the default 256-bit data width.
    localparam int BYTES_PER_BEAT = 32;

    // AXI bursts must not cross a 4 KB page.
    localparam int BOUNDARY_BYTES = 4096;
    localparam int BOUNDARY_SHIFT = 12;

endpackage

// File: rtl/axis_read_burst_calc.sv
// Burst sizing: min(remaining beats, BURST_MAX) and, when
// AXIS_READ_CTRL_BOUNDARY_EN is defined, also the beats left before the next
// 4 KB page. Purely combinational; the caller registers the result.
module axis_read_burst_calc
    import axis_read_ctrl_pkg::*;
#(
    parameter int CONFIG_DWIDTH  = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int BURST_MAX      = 16,
    parameter int BEAT_BYTES     = BYTES_PER_BEAT
)
(
    input  logic [CONFIG_DWIDTH-1:0]  remaining,
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    output logic [AXI_LEN_WIDTH:0]    burst_beats
);

    // Work width wide enough for the remaining count, BURST_MAX and the page room.
    localparam int CW         = (CONFIG_DWIDTH > 16) ? CONFIG_DWIDTH : 16;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

    logic [CW-1:0] rem_w;
    logic [CW-1:0] max_w;
    logic [CW-1:0] lim;
    logic          unused_bits;

`ifdef AXIS_READ_CTRL_BOUNDARY_EN
    logic [BOUNDARY_SHIFT:0] room_bytes;
    logic [CW-1:0]           room_beats;
`endif

    // Smallest of the limits; addr is beat aligned so the page room divides exactly.
    always_comb begin
        rem_w = CW'(remaining);
        max_w = CW'(BURST_MAX);
        lim   = (rem_w < max_w) ? rem_w : max_w;
`ifdef AXIS_READ_CTRL_BOUNDARY_EN
        room_bytes = (BOUNDARY_SHIFT + 1)'(BOUNDARY_BYTES) - {1'b0, addr[BOUNDARY_SHIFT-1:0]};
        room_beats = CW'(room_bytes >> BEAT_SHIFT);
        if (room_beats < lim) begin
            lim = room_beats;
        end
`endif
        burst_beats = lim[AXI_LEN_WIDTH:0];
    end

    assign unused_bits = ^{1'b0, lim[CW-1:AXI_LEN_WIDTH+1], addr};

endmodule

// File: rtl/axis_read_ctrl.sv
// AXI read-address controller: accepts a job (start address, length in narrow
// words), hands the length to the read-data unit, then issues AR bursts until
// all beats are requested. All outputs are registered.
// Optional macro AXIS_READ_CTRL_BOUNDARY_EN splits bursts at 4 KB pages.
module axis_read_ctrl
    import axis_read_ctrl_pkg::*;
#(
    parameter int CONFIG_AWIDTH  = 32,
    parameter int CONFIG_DWIDTH  = 32,
    parameter int WIDTH_RATIO    = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = BYTES_PER_BEAT * 8,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int BURST_MAX      = 16
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CONFIG_AWIDTH-1:0]  cfg_address,
    input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
    output logic [AXI_LEN_WIDTH-1:0]  axi_arlen,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    output logic [CONFIG_DWIDTH-1:0]  data_cfg_length,
    output logic                      data_cfg_valid,
    input  logic                      data_cfg_ready,
    output logic                      busy
);

    localparam int BEAT_BYTES  = AXI_DATA_WIDTH / 8;
    localparam int BEAT_SHIFT  = $clog2(BEAT_BYTES);
    localparam int RATIO_SHIFT = $clog2(WIDTH_RATIO);
    localparam int BW          = AXI_LEN_WIDTH + 1;

    state_t state_reg;
    state_t state_next;

    logic                      cfg_ready_reg;
    logic                      busy_reg;
    logic                      data_cfg_valid_reg;
    logic [CONFIG_DWIDTH-1:0]  data_cfg_length_reg;
    logic                      axi_arvalid_reg;
    logic [AXI_ADDR_WIDTH-1:0] axi_araddr_reg;
    logic [AXI_LEN_WIDTH-1:0]  axi_arlen_reg;

    logic [AXI_ADDR_WIDTH-1:0] addr_reg;
    logic [CONFIG_DWIDTH-1:0]  remaining_reg;
    logic [BW-1:0]             burst_reg;
    logic [BW-1:0]             burst_calc;

    logic                      cfg_fire;
    logic                      dc_fire;
    logic                      ar_fire;
    logic [CONFIG_DWIDTH:0]    beats_sum;
    logic [CONFIG_DWIDTH:0]    beats_full;
    logic [CONFIG_DWIDTH-1:0]  job_beats;
    logic [AXI_ADDR_WIDTH-1:0] cfg_addr_aligned;
    logic                      unused_bits;

    // cfg_ready is only high in IDLE, so a cfg handshake implies IDLE.
    assign cfg_fire = cfg_valid & cfg_ready_reg;
    assign dc_fire  = data_cfg_valid_reg & data_cfg_ready;
    assign ar_fire  = axi_arvalid_reg & axi_arready;

    // Beats = ceil(length / WIDTH_RATIO), one extra bit so the round-up cannot overflow.
    assign beats_sum        = {1'b0, cfg_length} + (CONFIG_DWIDTH + 1)'(WIDTH_RATIO - 1);
    assign beats_full       = beats_sum >> RATIO_SHIFT;
    assign job_beats        = beats_full[CONFIG_DWIDTH-1:0];
    assign cfg_addr_aligned = AXI_ADDR_WIDTH'(cfg_address) & ~AXI_ADDR_WIDTH'(BEAT_BYTES - 1);
    assign unused_bits      = beats_full[CONFIG_DWIDTH];

    axis_read_burst_calc #(
        .CONFIG_DWIDTH  (CONFIG_DWIDTH),
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .AXI_LEN_WIDTH  (AXI_LEN_WIDTH),
        .BURST_MAX      (BURST_MAX),
        .BEAT_BYTES     (BEAT_BYTES)
    ) u_burst_calc (
        .remaining   (remaining_reg),
        .addr        (addr_reg),
        .burst_beats (burst_calc)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a zero-length job is accepted but never leaves IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cfg_fire && (cfg_length != '0)) begin
                    state_next = DATA_CFG;
                end
            end
            DATA_CFG: begin
                if (dc_fire) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                state_next = ADDR;
            end
            ADDR: begin
                if (ar_fire) begin
                    state_next = (remaining_reg == CONFIG_DWIDTH'(burst_reg)) ? IDLE : CALC;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Job datapath and registered outputs, derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ready_reg       <= 1'b0;
            busy_reg            <= 1'b0;
            data_cfg_valid_reg  <= 1'b0;
            data_cfg_length_reg <= '0;
            axi_arvalid_reg     <= 1'b0;
            axi_araddr_reg      <= '0;
            axi_arlen_reg       <= '0;
            addr_reg            <= '0;
            remaining_reg       <= '0;
            burst_reg           <= '0;
        end else begin
            cfg_ready_reg      <= (state_next == IDLE);
            busy_reg           <= (state_next != IDLE);
            data_cfg_valid_reg <= (state_next == DATA_CFG);
            axi_arvalid_reg    <= (state_next == ADDR);
            if (cfg_fire) begin
                addr_reg            <= cfg_addr_aligned;
                remaining_reg       <= job_beats;
                data_cfg_length_reg <= cfg_length;
            end
            if (state_reg == CALC) begin
                burst_reg      <= burst_calc;
                axi_araddr_reg <= addr_reg;
                axi_arlen_reg  <= AXI_LEN_WIDTH'(burst_calc - 1'b1);
            end
            if (ar_fire) begin
                addr_reg      <= addr_reg + (AXI_ADDR_WIDTH'(burst_reg) << BEAT_SHIFT);
                remaining_reg <= remaining_reg - CONFIG_DWIDTH'(burst_reg);
            end
        end
    end

    assign cfg_ready       = cfg_ready_reg;
    assign busy            = busy_reg;
    assign data_cfg_valid  = data_cfg_valid_reg;
    assign data_cfg_length = data_cfg_length_reg;
    assign axi_arvalid     = axi_arvalid_reg;
    assign axi_araddr      = axi_araddr_reg;
    assign axi_arlen       = axi_arlen_reg;

endmodule

// File: tb/tb_axis_read_ctrl.sv
// Bench for axis_read_ctrl (default parameters, 32-byte beats, 8 words/beat).
// Job-level model: each accepted job expands into an expected data_cfg length
// and a list of (address, arlen) bursts; a negedge monitor checks every
// handshake against it. Honours AXIS_READ_CTRL_BOUNDARY_EN.
module tb_axis_read_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg_address = '0;
    logic [31:0] cfg_length = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic        axi_arvalid;
    logic        axi_arready = 1'b1;
    logic [31:0] data_cfg_length;
    logic        data_cfg_valid;
    logic        data_cfg_ready = 1'b1;
    logic        busy;

    axis_read_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_address     (cfg_address),
        .cfg_length      (cfg_length),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .axi_araddr      (axi_araddr),
        .axi_arlen       (axi_arlen),
        .axi_arvalid     (axi_arvalid),
        .axi_arready     (axi_arready),
        .data_cfg_length (data_cfg_length),
        .data_cfg_valid  (data_cfg_valid),
        .data_cfg_ready  (data_cfg_ready),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cycle = 0;
    logic rst_q = 1'b1;
    int ready_mode = 0;      // 0: always ready, 1: random, 2: arready held low
    int last_req_cycle = 0;

    longint      exp_dcl_q[$];
    logic [31:0] exp_ara_q[$];
    int          exp_arl_q[$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_len = '0;
    int          ar_hs = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cycle);
    endfunction

    // Expand a job into its expected bursts from the burst rules.
    function automatic void push_job(input logic [31:0] a, input logic [31:0] l);
        logic [31:0] addr;
        longint rem;
        longint b;
        longint room;
        addr = a & ~32'h1F;
        rem  = (longint'(l) + 7) / 8;
        if (l != 0) exp_dcl_q.push_back(longint'(l));
        while (rem > 0) begin
            b = (rem < 16) ? rem : 16;
`ifdef AXIS_READ_CTRL_BOUNDARY_EN
            room = (4096 - longint'(addr % 4096)) / 32;
            if (room < b) b = room;
`else
            room = b;
`endif
            exp_ara_q.push_back(addr);
            exp_arl_q.push_back(int'(b - 1));
            addr = addr + 32'(b * 32);
            rem  = rem - b;
        end
    endfunction

    always @(posedge clk) begin
        cycle <= cycle + 1;
        rst_q <= rst;
    end

    // Ready generator: sole driver of axi_arready and data_cfg_ready.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0: begin axi_arready = 1'b1; data_cfg_ready = 1'b1; end
                1: begin
                    axi_arready    = ($urandom_range(0, 2) != 0);
                    data_cfg_ready = ($urandom_range(0, 1) != 0);
                end
                default: begin axi_arready = 1'b0; data_cfg_ready = 1'b1; end
            endcase
        end
    end

    // Monitor: compares every handshake and stall cycle against the model.
    always @(negedge clk) begin
        if (rst) begin
            exp_dcl_q.delete();
            exp_ara_q.delete();
            exp_arl_q.delete();
            prev_stall <= 1'b0;
        end else if (!rst_q) begin
            check("ready_vs_busy", cfg_ready, !busy);
            if (prev_stall) begin
                check("ar_hold_valid", axi_arvalid, 1);
                check("ar_hold_addr", axi_araddr, prev_addr);
                check("ar_hold_len", axi_arlen, prev_len);
            end
            if (data_cfg_valid && data_cfg_ready) begin
                if (exp_dcl_q.size() == 0) check("unexpected_data_cfg", data_cfg_valid, 0);
                else check("data_cfg_length", data_cfg_length, exp_dcl_q.pop_front());
            end
            if (axi_arvalid && axi_arready) begin
                if (exp_ara_q.size() == 0) check("unexpected_ar", axi_arvalid, 0);
                else begin
                    check("ar_addr", axi_araddr, exp_ara_q.pop_front());
                    check("ar_len", axi_arlen, exp_arl_q.pop_front());
                end
                ar_hs <= ar_hs + 1;
            end
            prev_stall <= axi_arvalid && !axi_arready;
            prev_addr  <= axi_araddr;
            prev_len   <= axi_arlen;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_job(input logic [31:0] a, input logic [31:0] l);
        int n;
        n = 0;
        while (!cfg_ready && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        if (!cfg_ready) begin
            check("cfg_ready_timeout", cfg_ready, 1);
            return;
        end
        $display("job addr=0x%08h len=%0d cycle=%0d", a, l, cycle);
        cfg_address = a;
        cfg_length  = l;
        cfg_valid   = 1'b1;
        last_req_cycle = cycle;
        push_job(a, l);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((exp_ara_q.size() != 0 || exp_dcl_q.size() != 0 || !cfg_ready) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_done"}, (exp_ara_q.size() == 0 && exp_dcl_q.size() == 0 && cfg_ready) ? 1 : 0, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        logic [31:0] a;
        logic [31:0] l;

        // Reset values.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_arvalid", axi_arvalid, 0);
        check("rst_dcfg_valid", data_cfg_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_araddr", axi_araddr, 0);
        check("rst_arlen", axi_arlen, 0);
        check("rst_dcfg_len", data_cfg_length, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_cfg_ready", cfg_ready, 1);

        // Length 10 -> 2 beats, one AR at 0 with arlen 1, 3-cycle latency.
        send_job(32'h0, 32'd10);
        check("m10_count", exp_ara_q.size(), 1);
        check("m10_addr", exp_ara_q[0], 32'h0);
        check("m10_len", exp_arl_q[0], 1);
        n = 0;
        while (!axi_arvalid && n < 20) begin @(posedge clk); #1; n++; end
        check("first_ar_latency", cycle - last_req_cycle, 3);
        wait_idle("len10");
        check("len10_dcfg_len", data_cfg_length, 10);
        check("len10_busy", busy, 0);

        // Length 4096 -> 512 beats, 32 bursts of 16 at 0x200 strides.
        send_job(32'h0, 32'd4096);
        check("m4096_count", exp_ara_q.size(), 32);
        check("m4096_last_addr", exp_ara_q[31], 32'h3E00);
        check("m4096_len", exp_arl_q[0], 15);
        wait_idle("len4096");

        // 0xFC0, length 64 -> 8 beats, split at 0x1000 only with the boundary feature.
        send_job(32'hFC0, 32'd64);
`ifdef AXIS_READ_CTRL_BOUNDARY_EN
        check("m4k_count", exp_ara_q.size(), 2);
        check("m4k_addr0", exp_ara_q[0], 32'hFC0);
        check("m4k_len0", exp_arl_q[0], 1);
        check("m4k_addr1", exp_ara_q[1], 32'h1000);
        check("m4k_len1", exp_arl_q[1], 5);
`else
        check("m4k_count", exp_ara_q.size(), 1);
        check("m4k_addr0", exp_ara_q[0], 32'hFC0);
        check("m4k_len0", exp_arl_q[0], 7);
`endif
        wait_idle("boundary");

        // Zero length: accepted, nothing issued, ready again at once.
        send_job(32'h40, 32'd0);
        check("zero_cfg_ready", cfg_ready, 1);
        check("zero_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            check("zero_no_dcfg", data_cfg_valid, 0);
            check("zero_no_ar", axi_arvalid, 0);
            @(posedge clk); #1;
        end

        // arready held low: AR must hold steady (0x100, 2 beats).
        ready_mode = 2;
        send_job(32'h100, 32'd16);
        n = 0;
        while (!axi_arvalid && n < 20) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", axi_arvalid, 1);
            check("stall_addr", axi_araddr, 32'h100);
            check("stall_len", axi_arlen, 1);
            @(posedge clk); #1;
        end
        ready_mode = 0;
        wait_idle("stall");

        // Reset after the 3rd AR of a long job, then a fresh job.
        send_job(32'h10000, 32'd4096);
        base = ar_hs;
        n = 0;
        while (ar_hs < base + 3 && n < 200) begin @(posedge clk); #1; n++; end
        check("rst_mid_progress", (ar_hs >= base + 3) ? 1 : 0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_arvalid", axi_arvalid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cfg_ready", cfg_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_job(32'h2000, 32'd20);
        check("m20_count", exp_ara_q.size(), 1);
        check("m20_addr", exp_ara_q[0], 32'h2000);
        check("m20_len", exp_arl_q[0], 2);
        wait_idle("after_rst");

        // Randomized jobs with random backpressure, many near page ends.
        ready_mode = 1;
        for (int j = 0; j < 40; j++) begin
            a = $urandom();
            if ($urandom_range(0, 1) == 1) a[11:0] = 12'hF00 + 12'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) l = $urandom_range(0, 16);
            else l = $urandom_range(1, 1500);
            send_job(a, l);
        end
        wait_idle("random");
        ready_mode = 0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/axis_read_ctrl.md
AXIS_READ_CTRL -- requirements
Module: axis_read_ctrl

Interface
REQ-001 Parameter: CONFIG_AWIDTH, default 32, width of the configured start address.
REQ-002 Parameter: CONFIG_DWIDTH, default 32, width of the configured length (narrow words).
REQ-003 Parameter: WIDTH_RATIO, default 8, narrow words per AXI beat (power of two).
REQ-004 Parameter: AXI_ADDR_WIDTH, default 32; AXI_DATA_WIDTH, default 256; AXI_LEN_WIDTH, default 8.
REQ-005 Parameter: BURST_MAX, default 16, maximum beats per burst (1..2^AXI_LEN_WIDTH).
REQ-006 Port: clk  in  1  sole clock; all logic on rising edge.
REQ-007 Port: rst  in  1  synchronous, active-high reset.
REQ-008 Ports: cfg_address  in  CONFIG_AWIDTH; cfg_length  in  CONFIG_DWIDTH; cfg_valid  in  1; cfg_ready  out  1. This is the job request handshake.
REQ-009 Ports: axi_araddr  out  AXI_ADDR_WIDTH; axi_arlen  out  AXI_LEN_WIDTH; axi_arvalid  out  1; axi_arready  in  1. This is the AXI read-address channel.
REQ-010 Ports: data_cfg_length  out  CONFIG_DWIDTH; data_cfg_valid  out  1; data_cfg_ready  in  1. This is the length handoff to the downstream read-data unit.
REQ-011 Port: busy  out  1  high while a job is in progress.

Function
REQ-012 The FSM SHALL have states IDLE, DATA_CFG, ADDR and CALC, with cfg_ready=1 only in IDLE.
REQ-013 In IDLE, when cfg_valid&cfg_ready, the block SHALL latch the address (low log2(AXI_DATA_WIDTH/8) bits forced to 0) and the length, compute beats=ceil(length/WIDTH_RATIO), and go to DATA_CFG.
REQ-014 A zero-length job SHALL be accepted, SHALL issue no data_cfg and no AR, and SHALL return to IDLE the next cycle.
REQ-015 In DATA_CFG, data_cfg_valid SHALL be 1 and data_cfg_length SHALL equal the latched length; on data_cfg_ready the FSM SHALL go to CALC.
REQ-016 In CALC, burst beats SHALL be min(remaining beats, BURST_MAX, beats to the next 4 KB boundary when enabled); the FSM SHALL go to ADDR after one cycle.
REQ-017 In ADDR, axi_arvalid SHALL be 1, with axi_araddr=current address and axi_arlen=burst beats-1, all held stable until axi_arready.
REQ-018 On axi_arvalid&axi_arready, the address SHALL advance by beats*(AXI_DATA_WIDTH/8) and remaining beats SHALL decrease by burst beats.
REQ-019 After that handshake, the FSM SHALL go to IDLE if remaining reaches 0, otherwise to CALC.
REQ-020 All outputs SHALL be registered, and the request-to-first-AR latency SHALL be 3 cycles when data_cfg_ready is held at 1.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 Beat and address arithmetic SHALL be unsigned at full width, with address wrap modulo 2^AXI_ADDR_WIDTH.

Reset
REQ-023 When rst is asserted, the FSM SHALL enter IDLE, including when a job is in progress, and the job SHALL be abandoned.
REQ-024 Reset values SHALL be cfg_ready=0 during rst and 1 the first cycle after, axi_arvalid=0, data_cfg_valid=0, busy=0, axi_araddr=0, axi_arlen=0, data_cfg_length=0.

Configuration
REQ-025 Macro AXIS_READ_CTRL_BOUNDARY_EN: when defined, bursts SHALL be split so that no burst crosses a 4 KB address boundary.
REQ-026 When AXIS_READ_CTRL_BOUNDARY_EN is undefined, bursts SHALL be limited only by BURST_MAX and remaining beats.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, BYTES_PER_BEAT, and the 4 KB boundary constant.
REQ-028 The burst-size computation SHALL be the sub-module axis_read_burst_calc (combinational min logic, registered in CALC).

Verification (defaults; BYTES_PER_BEAT=32)
REQ-029 Bench SHALL cover: addr 0x0, length 10 -> data_cfg_length=10, one AR addr 0x0 arlen=1, then IDLE.
REQ-030 Bench SHALL cover: addr 0x0, length 4096 -> 32 ARs of arlen=15 at addresses 0x0, 0x200, ..., 0x3E00.
REQ-031 Bench SHALL cover, with macro defined: addr 0xFC0, length 64 -> AR 0xFC0 arlen=1, then AR 0x1000 arlen=5; with macro undefined, one AR at 0xFC0 with arlen=7.
REQ-032 Bench SHALL cover: length 0 -> no data_cfg_valid, no axi_arvalid, cfg_ready back high within 2 cycles.
REQ-033 Bench SHALL cover: axi_arready held low for 5 cycles -> axi_araddr and axi_arlen stable, axi_arvalid held high.
REQ-034 Bench SHALL cover: rst asserted mid-job after the 3rd AR -> axi_arvalid=0 next cycle, and a new job then starts cleanly from its own address.
